// File: rtl/rd_frame_fmt.sv
// -----------------------------------------------------------------------------
// rd_frame_fmt
//
// Final stage of the PL DDR3 read path, running in the pl_clk domain.
// Read-back words are buffered in a show-ahead FIFO. Every BURST_WORDS
// payload words are wrapped into a frame on the data2ps/valid2ps stream:
//   SYNC_WORD, frame counter, BURST_WORDS payload words, 32-bit additive
//   checksum of the payload words only.
// The stream feeds the PS-DDR write controller directly.
//
// Ports
//   pl_clk          clock, all logic on the rising edge
//   pl_rst_n        asynchronous active-low reset
//   pl_ddr_rd_en    read-back word valid (no backpressure toward the source)
//   pl_ddr_rd_data  read-back word, qualified by pl_ddr_rd_en
//   out_stall       1 = downstream cannot take a word this cycle
//   data2ps         framed output word (registered)
//   valid2ps        data2ps valid, one cycle per word (registered)
//   frame_cnt       number of completed frames, bumps when the checksum goes out
//   fifo_level      current FIFO occupancy
//   overflow        sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module rd_frame_fmt #(
    parameter int unsigned BURST_WORDS = 256,
    parameter int unsigned FIFO_AW     = 9,
    parameter logic [31:0] SYNC_WORD   = 32'hEB90_146F
) (
    input  logic               pl_clk,
    input  logic               pl_rst_n,
    input  logic               pl_ddr_rd_en,
    input  logic [31:0]        pl_ddr_rd_data,
    input  logic               out_stall,
    output logic [31:0]        data2ps,
    output logic               valid2ps,
    output logic [31:0]        frame_cnt,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    // Payload index runs 0..BURST_WORDS-1; keep at least one bit.
    localparam int unsigned CW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [CW-1:0]      LAST_IDX   = CW'(BURST_WORDS - 1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_CNT,
        S_PAY,
        S_CHK
    } state_t;

    // -------------------------------------------------------------------------
    // Show-ahead FIFO
    // -------------------------------------------------------------------------
    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic [FIFO_AW:0]   level_d;
    logic               overflow_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;
    logic [31:0]        head;

    state_t             state_q;
    state_t             state_d;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign head       = mem_q[rd_ptr_q];

    // Pop is decided here rather than in the FSM process so the push
    // qualification below can see it without a combinational loop.
    assign pop  = (state_q == S_PAY) && !out_stall && !fifo_empty;

    // A full FIFO still accepts a word when the head leaves in the same cycle;
    // the write lands in the slot being vacated.
    assign push = pl_ddr_rd_en && (!fifo_full || pop);
    assign drop = pl_ddr_rd_en && fifo_full && !pop;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset: contents are only observed through level_q.
    always_ff @(posedge pl_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pl_ddr_rd_data;
        end
    end

    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM
    // -------------------------------------------------------------------------
    logic [31:0]   data_q,  data_d;
    logic          valid_q, valid_d;
    logic [31:0]   frame_q, frame_d;
    logic [31:0]   sum_q,   sum_d;
    logic [CW-1:0] wcnt_q,  wcnt_d;

    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= '0;
            sum_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            sum_q   <= sum_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
        frame_d = frame_q;
        sum_d   = sum_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SYNC;
                end
            end

            S_SYNC: begin
                if (!out_stall) begin
                    data_d  = SYNC_WORD;
                    valid_d = 1'b1;
                    state_d = S_CNT;
                end
            end

            S_CNT: begin
                if (!out_stall) begin
                    data_d  = frame_q;
                    valid_d = 1'b1;
                    sum_d   = '0;
                    wcnt_d  = '0;
                    state_d = S_PAY;
                end
            end

            S_PAY: begin
                if (pop) begin
                    data_d  = head;
                    valid_d = 1'b1;
                    sum_d   = sum_q + head;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_IDX) begin
                        state_d = S_CHK;
                    end
                end
            end

            S_CHK: begin
                if (!out_stall) begin
                    data_d  = sum_q;
                    valid_d = 1'b1;
                    frame_d = frame_q + 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data2ps    = data_q;
    assign valid2ps   = valid_q;
    assign frame_cnt  = frame_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rd_frame_fmt.sv
// -----------------------------------------------------------------------------
// tb_rd_frame_fmt
//
// Scoreboard bench for rd_frame_fmt (BURST_WORDS=4, FIFO_AW=3). Every
// accepted input word updates a frame-level reference model that queues the
// complete expected output stream; a separate monitor pops and compares on
// each valid2ps.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rd_frame_fmt;

    localparam int unsigned BW    = 4;
    localparam int unsigned FAW   = 3;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] SYNC  = 32'hEB90_146F;

    logic              pl_clk = 1'b0;
    logic              pl_rst_n;
    logic              pl_ddr_rd_en;
    logic [31:0]       pl_ddr_rd_data;
    logic              out_stall;
    logic [31:0]       data2ps;
    logic              valid2ps;
    logic [31:0]       frame_cnt;
    logic [FAW:0]      fifo_level;
    logic              overflow;

    always #5 pl_clk = ~pl_clk;

    rd_frame_fmt #(
        .BURST_WORDS (BW),
        .FIFO_AW     (FAW),
        .SYNC_WORD   (SYNC)
    ) dut (
        .pl_clk         (pl_clk),
        .pl_rst_n       (pl_rst_n),
        .pl_ddr_rd_en   (pl_ddr_rd_en),
        .pl_ddr_rd_data (pl_ddr_rd_data),
        .out_stall      (out_stall),
        .data2ps        (data2ps),
        .valid2ps       (valid2ps),
        .frame_cnt      (frame_cnt),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    typedef struct {
        logic [31:0] w;
        bit          pay;
    } exp_t;

    exp_t        exp_q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          acc_total  = 0;   // words the model accepted
    int          pay_seen   = 0;   // payload words the monitor has seen leave
    bit          in_rst     = 1'b1;

    // Frame-level reference model state
    int unsigned m_pos    = 0;
    logic [31:0] m_sum    = '0;
    logic [31:0] m_frames = '0;

    function automatic void model_accept(logic [31:0] w);
        if (m_pos == 0) begin
            exp_q.push_back('{SYNC, 1'b0});
            exp_q.push_back('{m_frames, 1'b0});
        end
        exp_q.push_back('{w, 1'b1});
        m_sum = m_sum + w;
        m_pos++;
        acc_total++;
        if (m_pos == BW) begin
            exp_q.push_back('{m_sum, 1'b0});
            m_frames = m_frames + 1;
            m_pos    = 0;
            m_sum    = '0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Monitor: out_stall is captured at the edge that produced the output.
    initial begin : monitor
        bit   st;
        exp_t e;
        forever begin
            @(posedge pl_clk);
            st = out_stall;
            @(negedge pl_clk);
            if (!in_rst && valid2ps === 1'b1) begin
                checks++;
                if (st) begin
                    failures++;
                    $display("FAIL stall_emit valid2ps=1 required=0 data=%h", data2ps);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected got=%h required=none", data2ps);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", data2ps, e.w);
                    if (e.pay) pay_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit accept);
        pl_ddr_rd_en   = 1'b1;
        pl_ddr_rd_data = w;
        if (accept) model_accept(w);
        tick();
        pl_ddr_rd_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
        end
        repeat (3) tick();
    endtask

    initial begin : main
        int          first, last, nval, guard;
        logic [31:0] w;

        pl_rst_n       = 1'b0;
        pl_ddr_rd_en   = 1'b0;
        pl_ddr_rd_data = '0;
        out_stall      = 1'b0;
        repeat (3) @(posedge pl_clk);
        #1;
        check("rst_data",     data2ps,    32'h0);
        check("rst_valid",    valid2ps,   32'h0);
        check("rst_framecnt", frame_cnt,  32'h0);
        check("rst_level",    32'(fifo_level), 32'h0);
        check("rst_overflow", overflow,   32'h0);
        pl_rst_n = 1'b1;
        in_rst   = 1'b0;
        repeat (2) tick();

        // Single frame 1,2,3,4: latency and back-to-back emission
        first = -1; last = -1; nval = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
            end
            begin
                @(posedge pl_clk);  // edge carrying the first push
                for (int j = 0; j < 20; j++) begin
                    @(negedge pl_clk);
                    if (valid2ps === 1'b1) begin
                        if (first < 0) first = j;
                        last = j;
                        nval++;
                    end
                    @(posedge pl_clk);
                end
            end
        join
        #1;
        check("t1_first_latency", 32'(first), 32'd2);
        check("t1_span", 32'(last - first), 32'd6);
        check("t1_nwords", 32'(nval), 32'd7);
        wait_drain("t1");
        check("t1_framecnt", frame_cnt, 32'd1);

        // Stall held for 3 cycles in SYNC, PAY and CHK
        fork
            begin
                for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
            end
            begin
                @(posedge pl_clk);
                #1;
                for (int j = 1; j <= 24; j++) begin
                    out_stall = (j inside {2, 3, 4, 8, 9, 10, 14, 15, 16});
                    tick();
                end
                out_stall = 1'b0;
            end
        join
        wait_drain("t2");
        check("t2_framecnt", frame_cnt, 32'd2);

        // Sparse input: one word every 5th cycle
        for (int i = 0; i < 4; i++) begin
            push_word(32'h100 + 32'(i), 1'b1);
            repeat (4) tick();
        end
        wait_drain("t3");
        check("t3_framecnt", frame_cnt, 32'd3);

        // Checksum wrap, then a second frame right behind it
        push_word(32'hFFFF_FFFF, 1'b1);
        push_word(32'h0000_0002, 1'b1);
        push_word(32'h0, 1'b1);
        push_word(32'h0, 1'b1);
        check("t4_model_wrap_sum", exp_q[exp_q.size() - 1].w, 32'h0000_0001);
        for (int i = 0; i < 4; i++) push_word(32'h11 * 32'(i + 1), 1'b1);
        wait_drain("t4");
        check("t4_framecnt", frame_cnt, 32'd5);

        // Randomised traffic; pushes held back whenever the FIFO could be full
        for (int c = 0; c < 800; c++) begin
            out_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0 && (acc_total - pay_seen) < int'(DEPTH)) begin
                w              = $urandom;
                pl_ddr_rd_en   = 1'b1;
                pl_ddr_rd_data = w;
                model_accept(w);
            end else begin
                pl_ddr_rd_en = 1'b0;
            end
            tick();
        end
        pl_ddr_rd_en = 1'b0;
        out_stall    = 1'b0;
        guard        = 0;
        while (m_pos != 0 && guard < 200) begin
            if ((acc_total - pay_seen) < int'(DEPTH)) push_word($urandom, 1'b1);
            else tick();
            guard++;
        end
        wait_drain("rand");
        check("rand_framecnt", frame_cnt, m_frames);
        check("rand_overflow", overflow, 32'h0);

        // Overflow: output stalled, 10 pushes into an 8-deep FIFO
        out_stall = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) push_word(32'(i), (i <= int'(DEPTH)));
        tick();
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", overflow, 32'h1);
        out_stall = 1'b0;
        wait_drain("ovf");
        check("ovf_framecnt", frame_cnt, m_frames);
        check("ovf_sticky", overflow, 32'h1);

        // Reset in the middle of a payload
        push_word(32'h55, 1'b1);
        push_word(32'h66, 1'b1);
        repeat (8) tick();
        in_rst   = 1'b1;
        pl_rst_n = 1'b0;
        #1;
        check("midrst_data",     data2ps,   32'h0);
        check("midrst_valid",    valid2ps,  32'h0);
        check("midrst_framecnt", frame_cnt, 32'h0);
        check("midrst_level",    32'(fifo_level), 32'h0);
        check("midrst_overflow", overflow,  32'h0);
        @(posedge pl_clk);
        #1;
        pl_rst_n = 1'b1;
        exp_q.delete();
        m_pos     = 0;
        m_sum     = '0;
        m_frames  = '0;
        acc_total = 0;
        pay_seen  = 0;
        in_rst    = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 1'b1);
        wait_drain("postrst");
        check("postrst_framecnt", frame_cnt, 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_frame_fmt.md
Name: rd_frame_fmt

Overview:
- Downstream stage of the PL DDR3 read path, in the pl_clk domain.
- Consumes read-back words (pl_ddr_rd_en/pl_ddr_rd_data) and buffers them in an internal show-ahead FIFO.
- Wraps every BURST_WORDS payload words into a frame: sync word, frame counter, payload, 32-bit additive checksum.
- Output is data2ps/valid2ps, which feeds the PS-DDR write controller directly.

Parameters:
- BURST_WORDS, 256: payload words per frame; must be ≥ 1.
- FIFO_AW, 9: FIFO address width; depth = 2^FIFO_AW words.
- SYNC_WORD, 32'hEB90_146F: frame header constant.

Ports:
- pl_clk  in  1  clock; all logic on rising edge.
- pl_rst_n  in  1  reset, asynchronous, active-low.
- pl_ddr_rd_en  in  1  read-back word valid; no backpressure.
- pl_ddr_rd_data  in  32  read-back word, qualified by pl_ddr_rd_en.
- out_stall  in  1  1 = downstream cannot take a word this cycle.
- data2ps  out  32  framed output word.
- valid2ps  out  1  data2ps valid, single-cycle per word.
- frame_cnt  out  32  number of completed frames (updated when the checksum is emitted).
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - data2ps=0, valid2ps=0, frame_cnt=0, fifo_level=0, overflow=0.
  - FSM=IDLE, checksum=0, word counter=0, FIFO pointers=0.
  - Reset mid-frame abandons the frame; no tail word is emitted.
- FIFO (show-ahead; head word visible while non-empty):
  - Push on pl_ddr_rd_en when not full.
  - Push when full with a simultaneous pop: accepted.
  - Push when full without a pop: word dropped, overflow<=1 (stays 1 until reset).
  - fifo_level tracks push/pop in the same cycle; simultaneous push and pop leaves it unchanged.
- FSM (data2ps/valid2ps registered; valid2ps<=0 in any cycle nothing is emitted):
  - IDLE: FIFO non-empty -> SYNC (no emit).
  - SYNC: out_stall=0 -> emit SYNC_WORD, go to CNT. Otherwise hold.
  - CNT: out_stall=0 -> emit frame_cnt, checksum<=0, word counter<=0, go to PAY. Otherwise hold.
  - PAY: out_stall=0 and FIFO non-empty -> pop, emit head word, checksum<=checksum+word (mod 2^32), counter++. When counter==BURST_WORDS-1 at the pop -> CHK. If stalled or FIFO empty: no emit, no pop, hold.
  - CHK: out_stall=0 -> emit checksum, frame_cnt<=frame_cnt+1 (wraps 2^32->0), go to IDLE. Otherwise hold.
- Latency:
  - First word pushed at edge k into an empty FIFO, no stall.
  - SYNC valid after edge k+2, counter word after k+3, first payload word after k+4.
- Throughput:
  - One word per cycle when not stalled.
  - Frame overhead is 3 words plus 1 idle cycle (IDLE->SYNC).
- Checksum covers payload words only; header words are excluded.
- Input arriving during header or tail emission is buffered; no word is lost unless the FIFO is full.
- Back-to-back frames: after CHK the FSM always passes through one IDLE cycle.

Test Plan:
- Single frame, BURST_WORDS=4: push 1,2,3,4 on consecutive cycles, no stall -> valid2ps words EB90146F, 0, 1, 2, 3, 4, 0000000A on 7 consecutive cycles; frame_cnt=1.
- Stall in every state: out_stall=1 for 3 cycles in SYNC, PAY and CHK -> same 7-word sequence, no duplicates or drops, valid2ps=0 while stalled.
- Sparse input, BURST_WORDS=4: words arrive every 5th cycle -> payload gaps with valid2ps=0, FSM held in PAY, checksum correct.
- Overflow, FIFO_AW=3: out_stall=1, push 10 words -> fifo_level=8, overflow=1, words 9 and 10 lost. Release stall -> first frame carries words 1..4.
- Checksum wrap: payload FFFFFFFF, 00000002, 0, 0 -> checksum 00000001. Two frames -> counter words 0 then 1.
- Reset mid-PAY: pl_rst_n low for 1 cycle -> all outputs 0 immediately. After release, new input restarts at SYNC with frame counter 0.
